rgb_led_pwm_ctrl: RTL and testbench

//  Switch-driven controller for the board's RGB LEDs and mono LEDs, generalised to NUM_LEDS channels.

---
 rtl/rgb_led_pwm_ctrl_if.sv | 10 +
 rtl/rgb_led_pwm_ctrl.sv | 117 +++++++++++
 tb/tb_rgb_led_pwm_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rgb_led_pwm_ctrl_if.sv
// rgb_led_pwm_ctrl_if: raw switches in, RGB and mono LED drives out
interface rgb_led_pwm_ctrl_if #(parameter int NUM_LEDS = 4);
    logic [3:0]          sw;
    logic [NUM_LEDS-1:0] led_r;
    logic [NUM_LEDS-1:0] led_g;
    logic [NUM_LEDS-1:0] led_b;
    logic [NUM_LEDS-1:0] led;
    modport master (output sw, input led_r, led_g, led_b, led);
    modport slave (input sw, output led_r, led_g, led_b, led);
endinterface

// File: rtl/rgb_led_pwm_ctrl.sv
// rgb_led_pwm_ctrl: debounced switch control of RGB/mono LEDs with PWM and four display modes
module rgb_led_pwm_ctrl #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter logic [PWM_BITS-1:0] BRIGHT = PWM_BITS'(8'h20),
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_DIV = 50_000_000,
    parameter int BREATH_DIV = 100_000
) (
    input logic CLK100MHZ,
    input logic reset,
    rgb_led_pwm_ctrl_if.slave bus
);
    localparam int DB_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int BR_W = BREATH_DIV > 1 ? $clog2(BREATH_DIV) : 1;
    localparam int CI_W = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    typedef enum logic [1:0] {M_STATIC, M_BLINK, M_BREATHE, M_CHASE} mode_t;
    logic [3:0]          r_sync1, r_sync2, r_db;
    logic [DB_W-1:0]     r_db_cnt [4];
    logic [BL_W-1:0]     r_blink_cnt;
    logic [BR_W-1:0]     r_breath_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt, r_duty, r_level;
    logic                r_down, r_phase;
    logic [CI_W-1:0]     r_chase;
    mode_t               r_mode;
    logic [NUM_LEDS-1:0] r_led_r, r_led_g, r_led_b, r_led;
    logic [3:0]          w_flip;
    logic                w_rise, w_blink_tick, w_breath_tick, w_pwm_on;
    mode_t               w_mode_next;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [NUM_LEDS-1:0] w_sel, w_led;
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < 4; i++)
            w_flip[i] = (r_sync2[i] != r_db[i]) && (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
    end
    // sw_db[3] going 0->1 is exactly a bit-3 flip towards a high synchronised value
    assign w_rise        = w_flip[3] & r_sync2[3];
    assign w_mode_next   = mode_t'(r_mode + 2'd1);
    assign w_blink_tick  = r_blink_cnt == BL_W'(BLINK_DIV - 1);
    assign w_breath_tick = r_breath_cnt == BR_W'(BREATH_DIV - 1);
    assign w_pwm_on      = r_pwm_cnt < r_duty;
    assign w_duty_next   = r_mode == M_BREATHE ? r_level :
                           (r_mode == M_BLINK && !r_phase) ? '0 : BRIGHT;
    always_comb begin
        w_sel = '0;
        w_led = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_sel[i] = r_mode != M_CHASE || r_chase == CI_W'(i);
            w_led[i] = i < 4 && r_mode == 2'(i);
        end
    end
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_db         <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
            r_blink_cnt  <= '0;
            r_breath_cnt <= '0;
            r_pwm_cnt    <= '0;
            r_duty       <= '0;
            r_level      <= '0;
            r_down       <= 1'b0;
            r_phase      <= 1'b0;
            r_chase      <= '0;
            r_mode       <= M_STATIC;
            r_led_r      <= '0;
            r_led_g      <= '0;
            r_led_b      <= '0;
            r_led        <= '0;
        end else begin
            r_sync1 <= bus.sw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i] || w_flip[i]) r_db_cnt[i] <= '0;
                else r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                if (w_flip[i]) r_db[i] <= r_sync2[i];
            end
            r_blink_cnt  <= w_blink_tick ? '0 : r_blink_cnt + 1'b1;
            r_breath_cnt <= w_breath_tick ? '0 : r_breath_cnt + 1'b1;
            r_pwm_cnt    <= r_pwm_cnt + 1'b1;
            // duty only changes at the period boundary so no PWM period is cut short
            if (r_pwm_cnt == PWM_MAX) r_duty <= w_duty_next;
            if (w_rise) begin
                r_mode  <= w_mode_next;
                r_phase <= 1'b0;
                r_chase <= '0;
            end else if (w_blink_tick) begin
                r_phase <= ~r_phase;
                r_chase <= r_chase == CI_W'(NUM_LEDS - 1) ? '0 : r_chase + 1'b1;
            end
            if (w_rise && w_mode_next == M_BREATHE) begin
                r_level <= '0;
                r_down  <= 1'b0;
            end else if (w_breath_tick) begin
                if (!r_down) begin
                    r_down  <= r_level == PWM_MAX;
                    r_level <= r_level == PWM_MAX ? r_level - 1'b1 : r_level + 1'b1;
                end else begin
                    r_down  <= r_level != '0;
                    r_level <= r_level == '0 ? r_level + 1'b1 : r_level - 1'b1;
                end
            end
            r_led_b <= {NUM_LEDS{w_pwm_on & r_db[0]}} & w_sel;
            r_led_g <= {NUM_LEDS{w_pwm_on & r_db[1]}} & w_sel;
            r_led_r <= {NUM_LEDS{w_pwm_on & r_db[2]}} & w_sel;
            r_led   <= w_led;
        end
    end
    assign bus.led_r = r_led_r;
    assign bus.led_g = r_led_g;
    assign bus.led_b = r_led_b;
    assign bus.led   = r_led;
endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb_rgb_led_pwm_ctrl: directed and random switch stimulus, scoreboarded against a time-based model
module tb_rgb_led_pwm_ctrl;
    localparam int N = 4, P = 4, BR = 4, D = 4, B = 16, BD = 2;
    localparam int PMAX = (1 << P) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    rgb_led_pwm_ctrl_if #(.NUM_LEDS(N)) bus();
    rgb_led_pwm_ctrl #(
        .NUM_LEDS(N), .PWM_BITS(P), .BRIGHT(4'(BR)),
        .DEBOUNCE_CYCLES(D), .BLINK_DIV(B), .BREATH_DIV(BD)
    ) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic [N-1:0] b;
        logic [N-1:0] l;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int n, m_mode, mc, m_duty;
    logic [3:0] m_db;
    logic [3:0] swq[$];
    function automatic logic [3:0] swat(int m);
        return (m >= 0 && m < swq.size()) ? swq[m] : 4'h0;
    endfunction
    // brightness after k breathe steps: triangle 0..PMAX..0, period 2*PMAX
    function automatic int level_at(int k);
        int p;
        p = k % (2 * PMAX);
        return p <= PMAX ? p : 2 * PMAX - p;
    endfunction
    // model state is "after edge n"; outputs at edge n come from the state after edge n-1
    task automatic model_step(input logic rst_now, input logic [3:0] swin);
        exp_t e;
        int ticks, chase, lvl, dnext;
        logic on, stable;
        logic [3:0] sel, v;
        e = '0;
        if (rst_now) begin
            n = 0; m_db = 0; m_mode = 0; mc = 0; m_duty = 0;
            swq.delete();
            swq.push_back(4'h0);
            q.push_back(e);
            return;
        end
        n++;
        swq.push_back(swin);
        ticks = (n - 1) / B - mc / B;
        chase = ticks % N;
        lvl = level_at((n - 1) / BD - mc / BD);
        on = ((n - 1) % (PMAX + 1)) < m_duty;
        sel = m_mode == 3 ? 4'(1 << chase) : 4'hF;
        e.b = (on && m_db[0]) ? sel : 4'h0;
        e.g = (on && m_db[1]) ? sel : 4'h0;
        e.r = (on && m_db[2]) ? sel : 4'h0;
        e.l = 4'(1 << m_mode);
        dnext = m_mode == 2 ? lvl : (m_mode == 1 && ticks % 2 == 0) ? 0 : BR;
        for (int i = 0; i < 4; i++) begin
            stable = 1'b1;
            for (int k = 0; k < D; k++) begin
                v = swat(n - 2 - k);
                if (v[i] == m_db[i]) stable = 1'b0;
            end
            if (stable) begin
                m_db[i] = ~m_db[i];
                if (i == 3 && m_db[3]) begin
                    m_mode = (m_mode + 1) % 4;
                    mc = n;
                end
            end
        end
        if (n % (PMAX + 1) == 0) m_duty = dnext;
        q.push_back(e);
    endtask
    task automatic tick(input logic [3:0] s, input logic r);
        @(negedge clk);
        bus.sw = s;
        reset = r;
        @(posedge clk);
        model_step(r, s);
    endtask
    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic pulse3(input logic [3:0] base);
        repeat (8) tick(base | 4'h8, 1'b0);
        repeat (10) tick(base, 1'b0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.led_r, bus.led_g, bus.led_b, bus.led} !== e) begin
                    errors++;
                    $display("FAIL leds at %0t got r=%b g=%b b=%b led=%b expected r=%b g=%b b=%b led=%b",
                             $time, bus.led_r, bus.led_g, bus.led_b, bus.led, e.r, e.g, e.b, e.l);
                end
            end
        end
    end
    initial begin
        int cnt;
        logic bad;
        logic [3:0] v;
        int len;
        bus.sw = 4'h0;
        repeat (2) tick(4'h0, 1'b1);
        repeat (20) tick(4'h1, 1'b0);
        cnt = 0;
        repeat (16) begin
            tick(4'h1, 1'b0);
            #1;
            if (bus.led_b == 4'hF) cnt++;
        end
        chk("t1_blue_duty", 16'(cnt), 16'd4);
        chk("t1_mode_led", 16'(bus.led), 16'h1);
        tick(4'h0, 1'b1);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(((k / 2) % 2) ? 4'h1 : 4'h0, 1'b0);
            #1;
            bad |= |{bus.led_r, bus.led_g, bus.led_b};
        end
        chk("t2_bounce_rgb", 16'(bad), 16'h0);
        tick(4'h0, 1'b1);
        repeat (10) tick(4'h7, 1'b0);
        pulse3(4'h7); #1; chk("t3_adv1", 16'(bus.led), 16'h2);
        pulse3(4'h7); #1; chk("t3_adv2", 16'(bus.led), 16'h4);
        pulse3(4'h7); #1; chk("t3_adv3", 16'(bus.led), 16'h8);
        pulse3(4'h7); #1; chk("t3_adv4", 16'(bus.led), 16'h1);
        repeat (200) tick(4'hF, 1'b0);
        repeat (10) tick(4'h7, 1'b0);
        #1; chk("t3_hold_once", 16'(bus.led), 16'h2);
        repeat (64) tick(4'h4, 1'b0);
        pulse3(4'h2);
        pulse3(4'h2);
        #1; chk("t5_chase_mode", 16'(bus.led), 16'h8);
        bad = 1'b0;
        repeat (80) begin
            tick(4'h2, 1'b0);
            #1;
            bad |= |{bus.led_r, bus.led_b} || ($countones(bus.led_g) > 1);
        end
        chk("t5_single_green", 16'(bad), 16'h0);
        tick(4'h7, 1'b1);
        pulse3(4'h7);
        pulse3(4'h7);
        repeat (20) tick(4'h7, 1'b0);
        #1; chk("t6_breathe_mode", 16'(bus.led), 16'h4);
        tick(4'h7, 1'b1);
        #1; chk("t6_reset_zero", {bus.led_r, bus.led_g, bus.led_b, bus.led}, 16'h0);
        tick(4'h7, 1'b0);
        #1; chk("t6_static_led", 16'(bus.led), 16'h1);
        for (int s = 0; s < 400; s++) begin
            v = 4'($urandom);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 99) == 0) tick(v, 1'b1);
            repeat (len) tick(v, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
